// File: rtl/diff_serial_tx.sv
// diff_serial_tx: encodes a prefix word P into a difference word D
// (D[0] = ~P[0], D[i] = P[i] ^ P[i-1]) and sends D LSB-first on a single
// idle-high line as a start bit, WIDTH data bits and a stop bit. Each bit is
// held for BIT_CYCLES clocks.
// All outputs are registered. They are computed from the next-state values,
// so the line changes on the same edge as the state does.

module diff_serial_tx #(
  parameter int WIDTH      = 16,
  parameter int BIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
  output logic [WIDTH-1:0] diff_word,
  output logic             tx_bit,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // D[i] = P[i] ^ P[i-1], with P[-1] taken as 1 so that D[0] = ~P[0]
  function automatic logic [WIDTH-1:0] encode(input logic [WIDTH-1:0] p);
    return p ^ {p[WIDTH-2:0], 1'b1};
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic            tx_bit_q, tx_bit_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ready_q, ready_d;
  logic            bit_end_s;

  // Next-state, counter and output computation
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    idx_d     = idx_q;
    diff_d    = diff_q;
    done_d    = 1'b0;
    tx_bit_d  = 1'b1;
    bit_end_s = (cyc_q == CYC_LAST);

    case (state_q)
      ST_IDLE: begin
        // in_ready is exactly "state is IDLE", so in_valid alone qualifies accept
        if (in_valid) begin
          diff_d  = encode(in_word);
          state_d = ST_START;
          cyc_d   = '0;
          idx_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          cyc_d   = '0;
          idx_d   = '0;
          state_d = ST_DATA;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          cyc_d = '0;
          // hold the index at the last bit rather than wrapping
          if (idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          cyc_d   = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = '0;
        idx_d   = '0;
      end
    endcase

    case (state_d)
      ST_START: tx_bit_d = 1'b0;
      ST_DATA:  tx_bit_d = diff_d[idx_d];
      default:  tx_bit_d = 1'b1;
    endcase

    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  // State, counters and registered outputs with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cyc_q    <= '0;
      idx_q    <= '0;
      diff_q   <= '0;
      tx_bit_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      idx_q    <= idx_d;
      diff_q   <= diff_d;
      tx_bit_q <= tx_bit_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign in_ready  = ready_q;
  assign diff_word = diff_q;
  assign tx_bit    = tx_bit_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_diff_serial_tx.sv
// Self-checking bench for diff_serial_tx: a 16-bit/4-cycle instance and an
// 8-bit/1-cycle instance, checked against a word-level reference model.

module tb_diff_serial_tx;

  localparam int W   = 16;
  localparam int BC  = 4;
  localparam int W8  = 8;
  localparam int BC8 = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_word;
  logic        in_ready;
  logic [15:0] diff_word;
  logic        tx_bit, tx_busy, tx_done;

  logic        in_valid8;
  logic [7:0]  in_word8;
  logic        in_ready8;
  logic [7:0]  diff_word8;
  logic        tx_bit8, tx_busy8, tx_done8;

  int n_tests = 0;
  int n_fail  = 0;

  // 100 MHz clock
  always #5 clk = ~clk;

  diff_serial_tx #(.WIDTH(W), .BIT_CYCLES(BC)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .diff_word(diff_word), .tx_bit(tx_bit),
    .tx_busy(tx_busy), .tx_done(tx_done)
  );

  diff_serial_tx #(.WIDTH(W8), .BIT_CYCLES(BC8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_word(in_word8), .diff_word(diff_word8), .tx_bit(tx_bit8),
    .tx_busy(tx_busy8), .tx_done(tx_done8)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference encoder straight from the bit rule
  function automatic logic [31:0] ref_encode(input logic [31:0] p, input int w);
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < w; i++) begin
      if (i == 0) d[i] = ~p[0];
      else        d[i] = p[i] ^ p[i-1];
    end
    return d;
  endfunction

  // Receiver-side decoder: P[0] = ~D[0], P[i] = D[i] ^ P[i-1]
  function automatic logic [31:0] ref_decode(input logic [31:0] d, input int w);
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < w; i++) begin
      if (i == 0) p[i] = ~d[0];
      else        p[i] = d[i] ^ p[i-1];
    end
    return p;
  endfunction

  task automatic wait_done16();
    int cnt;
    cnt = 0;
    while (tx_done !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("done_timeout", tx_done, 1);
  endtask

  // mode 0: plain frame, 1: in_valid held through frame, 2: in_valid pulsed while busy
  task automatic run16(input logic [15:0] p, input int mode);
    logic [31:0] d;
    logic [15:0] rb;
    logic        exp_line[$];
    int          errs;
    d = ref_encode({16'h0, p}, W);
    exp_line = {};
    repeat (BC) exp_line.push_back(1'b0);
    for (int i = 0; i < W; i++) repeat (BC) exp_line.push_back(d[i]);
    repeat (BC) exp_line.push_back(1'b1);

    @(negedge clk);
    check_eq("ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_word  = p;
    @(negedge clk);
    if (mode != 1) in_valid = 1'b0;
    check_eq("diff_word", diff_word, d);
    errs = 0;
    rb   = '0;
    for (int k = 0; k < (W + 2) * BC; k++) begin
      if (tx_bit !== exp_line[k] || tx_busy !== 1'b1 || tx_done !== 1'b0 || in_ready !== 1'b0)
        errs++;
      if (k >= BC && k < (W + 1) * BC && (k % BC) == BC / 2) rb[(k / BC) - 1] = tx_bit;
      if (mode == 2 && k == 20) begin
        in_valid = 1'b1;
        in_word  = 16'($urandom);
      end
      if (mode == 2 && k == 22) in_valid = 1'b0;
      @(negedge clk);
    end
    check_eq("line", errs, 0);
    check_eq("done_pulse", tx_done, 1);
    check_eq("ready_done", in_ready, 1);
    check_eq("busy_end", tx_busy, 0);
    check_eq("diff_hold", diff_word, d);
    check_eq("roundtrip", ref_decode({16'h0, rb}, W), {16'h0, p});
    if (mode == 1) begin
      @(negedge clk);
      check_eq("b2b_start", {tx_busy, tx_bit, in_ready}, 3'b100);
      in_valid = 1'b0;
      wait_done16();
    end
  endtask

  task automatic run8(input logic [7:0] p);
    logic [31:0] d;
    logic [7:0]  rb;
    logic        exp_line[$];
    int          errs;
    d = ref_encode({24'h0, p}, W8);
    exp_line = {};
    exp_line.push_back(1'b0);
    for (int i = 0; i < W8; i++) exp_line.push_back(d[i]);
    exp_line.push_back(1'b1);

    @(negedge clk);
    in_valid8 = 1'b1;
    in_word8  = p;
    @(negedge clk);
    in_valid8 = 1'b0;
    check_eq("diff8", diff_word8, d);
    errs = 0;
    rb   = '0;
    for (int k = 0; k < (W8 + 2) * BC8; k++) begin
      if (tx_bit8 !== exp_line[k] || tx_busy8 !== 1'b1 || tx_done8 !== 1'b0) errs++;
      if (k >= 1 && k <= W8) rb[k-1] = tx_bit8;
      @(negedge clk);
    end
    check_eq("line8", errs, 0);
    check_eq("done8", tx_done8, 1);
    check_eq("roundtrip8", ref_decode({24'h0, rb}, W8), {24'h0, p});
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_word   = '0;
    in_valid8 = 1'b0;
    in_word8  = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_txbit", tx_bit, 1);
    check_eq("rst_busy", tx_busy, 0);
    check_eq("rst_done", tx_done, 0);
    check_eq("rst_diff", diff_word, 0);
    check_eq("rst_txbit8", tx_bit8, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", in_ready, 1);

    // directed words
    run16(16'h0000, 0);
    run16(16'h5555, 0);
    run16(16'hFFFF, 1);
    run16(16'h1234, 2);

    // reset in the middle of a frame
    @(negedge clk);
    in_valid = 1'b1;
    in_word  = 16'hBEEF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("midrst_txbit", tx_bit, 1);
    check_eq("midrst_busy", tx_busy, 0);
    check_eq("midrst_ready", in_ready, 1);
    check_eq("midrst_done", tx_done, 0);
    check_eq("midrst_diff", diff_word, 0);
    dcount = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_done === 1'b1 || tx_bit !== 1'b1) dcount++;
    end
    check_eq("midrst_quiet", dcount, 0);
    run16(16'hBEEF, 0);

    // randomized frames on the wide instance
    for (int n = 0; n < 200; n++) run16(16'($urandom), int'($urandom_range(0, 2)));

    // one-cycle-per-bit instance
    run8(8'hA5);
    for (int n = 0; n < 30; n++) run8(8'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
